// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes and traps.
// Define MC_PERF_CNT_EN to add the cycle and retired-instruction counters.
module mc_ctrl_fsm #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic [2:0] state,
  output logic       trap,
  output logic       trap_cause
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [1:0] C_ALU   = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;
  localparam logic [1:0] C_BR    = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] cls_q, cls_d;
  logic [7:0] wait_q, wait_d;
  logic       cause_q, cause_d;
  logic       retire;

  // The opcode class is captured in DECODE so later states never depend on Op.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (Op)
          7'b0110011, 7'b0010011: cls_d = C_ALU;
          7'b0000011:             cls_d = C_LOAD;
          7'b0100011:             cls_d = C_STORE;
          7'b1100011:             cls_d = C_BR;
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_ALU:          state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
          retire  = (cls_q == C_STORE);
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Staying in a request state means ready was low; any transition restarts the count.
  always_comb begin
    wait_d = 8'd0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)))
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_ALU;
      wait_q  <= 8'd0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Outputs are forced low during reset so a pending request drops immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        S_EXEC: begin
          if (cls_q == C_BR) begin
            PCSrc   = 1'b1;
            PCWrite = Zero;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          MemWrite = (cls_q == C_STORE);
        end
        S_WB:    RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state      = reset ? 3'd0 : state_q;
  assign trap       = !reset && (state_q == S_TRAP);
  assign trap_cause = !reset && cause_q;

`ifdef MC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_ONE;
      if (retire) ret_q <= ret_q + CNT_ONE;
    end
  end

  assign cycle_cnt   = reset ? '0 : cyc_q;
  assign instret_cnt = reset ? '0 : ret_q;
`else
  logic retire_unused;
  assign retire_unused = retire;
`endif

endmodule
